// File: rtl/rv32_encode_pkg.sv
// Shared types for the RV32I instruction encoder: formats, opcodes, buffer entry.
package rv32_encode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] OP     = 7'h33;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               err;
    } entry_t;

endpackage

// File: rtl/instruction_encode_unit_if.sv
// Field-bundle input and encoded-word output handshakes of the encoder.
interface instruction_encode_unit_if;
    import rv32_encode_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_fmt;
    logic [6:0]           in_opcode;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [REG_W-1:0]     in_rd;
    logic [REG_W-1:0]     in_rs1;
    logic [REG_W-1:0]     in_rs2;
    logic [31:0]          in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic                 out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/encode_skid_buffer.sv
// Two-entry in-order FIFO with registered ready/valid flags.
module encode_skid_buffer
    import rv32_encode_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    logic [1:0] occ;
    logic [1:0] occ_next;
    logic       rd_ptr;
    logic       wr_ptr;
    entry_t     mem [2];
    logic       push;
    logic       pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = mem[rd_ptr];

    // Occupancy after this edge's push/pop.
    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ - 2'd1;
        end
    end

    // Storage, pointers and the registered flags derived from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ       <= occ_next;
            in_ready  <= (occ_next < 2'd2);
            out_valid <= (occ_next != 2'd0);
        end
    end

endmodule

// File: rtl/instruction_encode_unit.sv
// Packs decoded RV32I fields into a 32-bit instruction word behind a 2-entry buffer.
// Optional build macro: ENCODE_RANGE_CHECK_EN flags immediates that do not fit.
module instruction_encode_unit
    import rv32_encode_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_encode_unit_if.slave  bus,
    output logic [CNT_W-1:0]          enc_count
);

    logic [INSTR_W-1:0] enc_instr_c;
    logic               enc_err_c;
    logic [31:0]        imm;
    entry_t             push_data;
    entry_t             head;
    logic               accept;

    assign imm = bus.in_imm;

    // Combinational field placement per instruction format.
    always_comb begin
        enc_instr_c = '0;
        enc_err_c   = 1'b0;
        case (bus.in_fmt)
            FMT_R: begin
                enc_instr_c = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_opcode};
            end
            FMT_I: begin
                enc_instr_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                               bus.in_opcode};
`ifdef ENCODE_RANGE_CHECK_EN
                enc_err_c = !((&imm[31:11]) || !(|imm[31:11]));
`endif
            end
            FMT_S: begin
                enc_instr_c = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               imm[4:0], bus.in_opcode};
`ifdef ENCODE_RANGE_CHECK_EN
                enc_err_c = !((&imm[31:11]) || !(|imm[31:11]));
`endif
            end
            FMT_B: begin
                enc_instr_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                               imm[4:1], imm[11], bus.in_opcode};
`ifdef ENCODE_RANGE_CHECK_EN
                enc_err_c = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
`endif
            end
            FMT_U: begin
                enc_instr_c = {imm[31:12], bus.in_rd, bus.in_opcode};
`ifdef ENCODE_RANGE_CHECK_EN
                enc_err_c = |imm[11:0];
`endif
            end
            FMT_J: begin
                enc_instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd,
                               bus.in_opcode};
`ifdef ENCODE_RANGE_CHECK_EN
                enc_err_c = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
`endif
            end
            default: begin
                enc_instr_c = '0;
                enc_err_c   = 1'b1;
            end
        endcase
    end

    assign push_data = '{instr: enc_instr_c, err: enc_err_c};
    assign accept    = bus.in_valid && bus.in_ready;

    encode_skid_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (push_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head)
    );

    assign bus.out_instr = head.instr;
    assign bus.out_err   = head.err;

    // Count every accepted bundle, erroneous ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (accept) begin
            enc_count <= enc_count + CNT_W'(1);
        end
    end

endmodule
